// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serialises one parallel word per accepted request into an asynchronous UART
// frame: one start bit (0), WIDTH data bits LSB first, an optional parity bit,
// and one stop bit (1). Every serial bit is held for CLKS_PER_BIT clk cycles.
// All outputs come straight from flops.
//
// Parameters
//   WIDTH         data bits per frame (5..9)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY_EN     1 = append a parity bit after the data, 0 = no parity bit
//   PARITY_ODD    0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//
// Ports
//   clk      system clock
//   arst_n   asynchronous reset, active-low
//   rst      synchronous reset, active-high, overrides every other input
//   tx_en    enable; gates acceptance of start only, never aborts a frame
//   start    send request, sampled only while idle
//   data_in  word to send, captured on the accepting edge
//   tx_out   serial line, idles high
//   busy     high while a frame is in progress
//   done     one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module uart_transmitter #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(WIDTH - 1);
    localparam logic             PAR_ODD_BIT = (PARITY_ODD != 0);
    localparam logic             HAS_PARITY  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // cycles spent in the current bit
    logic [BIT_W-1:0]   bit_q, bit_d;       // index of the data bit on the line
    logic [WIDTH-1:0]   shift_q, shift_d;   // data word, shifted right per bit
    logic               par_q, par_d;       // parity bit, computed at acceptance
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;

    // Last cycle of the current serial bit: the next edge is a bit boundary.
    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state logic. Output registers are loaded with the value the line
    // must carry after the edge, so tx_out only moves on bit boundaries.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_en && start) begin
                    state_d = S_START;
                    shift_d = data_in;
                    par_d   = (^data_in) ^ PAR_ODD_BIT;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        if (HAS_PARITY) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Bit 0 of the shifter is on the line now; bit 1 is next.
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Synchronous reset aborts any frame and drops a coincident start.
        if (rst) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            // NOTE: the shift register is a plain register, not a memory, so
            // clearing it on reset is cheap and keeps the frame deterministic.
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Three transmitter instances share clock and resets:
//   0: even parity, 1: odd parity, 2: no parity; all with CLKS_PER_BIT = 4.
// Stimulus pushes the hand-computed frame (bit 0 = start bit) into a queue.
// One monitor per instance detects a start bit on the line, pops the expected
// frame and compares every cycle of every bit, plus busy/done behaviour.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int C = 4;

    typedef struct {
        int          inst;
        logic [10:0] bits;     // transmission order, bits[0] first
        int          nbits;
        bit          aborted;  // frame is expected to be cut short by a reset
    } exp_t;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       rst;
    logic       tx_en;
    logic [2:0] start;
    logic [7:0] data_s [3];
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .arst_n(arst_n), .rst(rst), .tx_en(tx_en), .start(start[0]),
        .data_in(data_s[0]), .tx_out(tx[0]), .busy(busy[0]), .done(done[0])
    );

    uart_transmitter #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .arst_n(arst_n), .rst(rst), .tx_en(tx_en), .start(start[1]),
        .data_in(data_s[1]), .tx_out(tx[1]), .busy(busy[1]), .done(done[1])
    );

    uart_transmitter #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
        .clk(clk), .arst_n(arst_n), .rst(rst), .tx_en(tx_en), .start(start[2]),
        .data_in(data_s[2]), .tx_out(tx[2]), .busy(busy[2]), .done(done[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int i, input logic [10:0] bits, input int nb, input bit ab);
        exp_t e;
        e.inst    = i;
        e.bits    = bits;
        e.nbits   = nb;
        e.aborted = ab;
        exp_q.push_back(e);
    endtask

    // Issue a one-cycle start; the accepting edge is the posedge inside tick().
    task automatic send(input int i, input logic [7:0] d, input logic [10:0] bits,
                        input int nb, input bit ab);
        push_exp(i, bits, nb, ab);
        data_s[i] = d;
        start[i]  = 1'b1;
        tick();
        start[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done[i] === 1'b1) seen = 1'b1;
        end
        if (!seen) check($sformatf("done timeout inst%0d", i), 32'd0, 32'd1);
        tick();
    endtask

    // Monitors: one per instance, sampling on the falling edge.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial begin
            logic prev;
            exp_t e;
            bit   ab, bok, busy_ok, done_ok;
            prev = 1'bx;
            forever begin
                @(negedge clk);
                if (arst_n === 1'b1 && done[g] === 1'b1)
                    check($sformatf("stray done inst%0d", g), 32'd1, 32'd0);
                if (prev === 1'b1 && tx[g] === 1'b0 && arst_n === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected frame inst%0d", g), 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("frame owner inst%0d", g), g, e.inst);
                        ab      = 1'b0;
                        busy_ok = 1'b1;
                        done_ok = 1'b1;
                        for (int b = 0; b < e.nbits && !ab; b++) begin
                            bok = 1'b1;
                            for (int c = 0; c < C && !ab; c++) begin
                                if (b != 0 || c != 0) @(negedge clk);
                                if (rst === 1'b1 || arst_n !== 1'b1) begin
                                    ab = 1'b1;
                                end else begin
                                    if (tx[g] !== e.bits[b]) bok = 1'b0;
                                    if (busy[g] !== 1'b1)    busy_ok = 1'b0;
                                    if (done[g] !== 1'b0)    done_ok = 1'b0;
                                end
                            end
                            if (!ab && !e.aborted)
                                check($sformatf("inst%0d frame bit%0d", g, b), bok, 1'b1);
                        end
                        check($sformatf("inst%0d frame aborted", g), ab, e.aborted);
                        if (!ab) begin
                            check($sformatf("inst%0d busy in frame", g), busy_ok, 1'b1);
                            check($sformatf("inst%0d done low in frame", g), done_ok, 1'b1);
                            @(negedge clk);
                            check($sformatf("inst%0d done pulse", g), done[g], 1'b1);
                            check($sformatf("inst%0d busy drop", g), busy[g], 1'b0);
                            check($sformatf("inst%0d line idle after stop", g), tx[g], 1'b1);
                        end
                    end
                end
                prev = tx[g];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0;
        rst    = 1'b0;
        tx_en  = 1'b1;
        start  = '0;
        for (int i = 0; i < 3; i++) data_s[i] = '0;

        #12;
        check("reset tx_out", tx, 3'b111);
        check("reset busy", busy, 3'b000);
        check("reset done", done, 3'b000);
        @(posedge clk);
        #3 arst_n = 1'b1;
        repeat (3) tick();

        // 1: even parity, 0xA5 -> 0,10100101(LSB first),0,1
        send(0, 8'hA5, 11'b1_0_10100101_0, 11, 1'b0);
        wait_done(0, 60);

        // 2: odd parity, 0x07 -> parity 0; 0x00 -> parity 1
        send(1, 8'h07, 11'b1_0_00000111_0, 11, 1'b0);
        wait_done(1, 60);
        send(1, 8'h00, 11'b1_1_00000000_0, 11, 1'b0);
        wait_done(1, 60);

        // 3: no parity, 0xFF then back-to-back 0x00 requested in the done cycle
        send(2, 8'hFF, 11'b0_1_11111111_0, 10, 1'b0);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 60 && !seen; n++) begin
                @(negedge clk);
                if (done[2] === 1'b1) seen = 1'b1;
            end
            check("b2b done seen", seen, 1'b1);
        end
        push_exp(2, 11'b0_1_00000000_0, 10, 1'b0);
        data_s[2] = 8'h00;
        start[2]  = 1'b1;
        tick();
        start[2]  = 1'b0;
        check("b2b start bit", tx[2], 1'b0);
        check("b2b busy", busy[2], 1'b1);
        wait_done(2, 60);

        // 4: 0x3C with a start pulse while busy, data_in change and tx_en drop
        send(0, 8'h3C, 11'b1_0_00111100_0, 11, 1'b0);
        repeat (6) tick();
        data_s[0] = 8'hFF;
        start[0]  = 1'b1;
        tick();
        start[0]  = 1'b0;
        repeat (10) tick();
        tx_en = 1'b0;
        wait_done(0, 60);
        tx_en = 1'b1;
        repeat (5 * C) tick();
        check("no queued frame busy", busy[0], 1'b0);
        check("no queued frame line", tx[0], 1'b1);

        // 5: synchronous reset during data bit 3, then a clean 0x81 frame
        send(0, 8'hC3, 11'b0, 11, 1'b1);
        repeat (4 * C + 1) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst abort tx_out", tx[0], 1'b1);
        check("rst abort busy", busy[0], 1'b0);
        check("rst abort done", done[0], 1'b0);
        repeat (3) tick();
        check("rst abort done later", done[0], 1'b0);
        send(0, 8'h81, 11'b1_0_10000001_0, 11, 1'b0);
        wait_done(0, 60);

        // 6: asynchronous reset during the parity bit
        send(0, 8'h55, 11'b0, 11, 1'b1);
        repeat (9 * C) tick();
        #2 arst_n = 1'b0;
        #1;
        check("arst immediate tx_out", tx[0], 1'b1);
        check("arst immediate busy", busy[0], 1'b0);
        data_s[0] = 8'hFF;
        start[0]  = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("arst holds tx_out", tx[0], 1'b1);
        check("arst holds busy", busy[0], 1'b0);
        start[0] = 1'b0;
        arst_n   = 1'b1;
        tick();
        tx_en     = 1'b0;
        data_s[0] = 8'h0F;
        start[0]  = 1'b1;
        repeat (3) tick();
        start[0]  = 1'b0;
        check("tx_en=0 start ignored busy", busy[0], 1'b0);
        repeat (3 * C) tick();
        check("tx_en=0 start ignored line", tx[0], 1'b1);
        tx_en = 1'b1;

        repeat (5) tick();
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
